// File: rtl/mult_pipe_stall_pkg.sv
// Shared constants and configuration checks for the stalling pipelined multiplier.
package mult_pipe_stall_pkg;

  localparam logic MULT_MODE_LO = 1'b0;
  localparam logic MULT_MODE_HI = 1'b1;

  localparam int XLEN_DEFAULT       = 64;
  localparam int NUM_STAGES_DEFAULT = 4;
  localparam int IR_W_DEFAULT       = 32;
  localparam int REG_W_DEFAULT      = 5;
  localparam int NPC_W              = 64;

  // Each stage consumes an equal-width chunk of the multiplier.
  function automatic bit stages_divide(input int xlen, input int stages);
    return (stages > 0) && ((xlen % stages) == 0);
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One multiplier pipeline stage: adds one partial product on load, holds when stalled.
module mult_pipe_stage
  import mult_pipe_stall_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CW    = XLEN_DEFAULT / NUM_STAGES_DEFAULT,
  parameter int IR_W  = IR_W_DEFAULT,
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              advance,
  input  logic              prev_mode,
  input  logic [IR_W-1:0]   prev_ir,
  input  logic [NPC_W-1:0]  prev_npc,
  input  logic [REG_W-1:0]  prev_dest,
  input  logic [XLEN-1:0]   prev_mplier,
  input  logic [2*XLEN-1:0] prev_mcand,
  input  logic [2*XLEN-1:0] prev_acc,
  output logic              valid,
  output logic              mode,
  output logic [IR_W-1:0]   ir,
  output logic [NPC_W-1:0]  npc,
  output logic [REG_W-1:0]  dest,
  output logic [XLEN-1:0]   mplier,
  output logic [2*XLEN-1:0] mcand,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] chunk_ext;
  logic [2*XLEN-1:0] next_acc;

  assign chunk_ext = {{(2*XLEN-CW){1'b0}}, prev_mplier[CW-1:0]};
  assign next_acc  = prev_acc + (chunk_ext * prev_mcand);

  // Flush beats load; a stage that only drains drops its valid but keeps stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      mode   <= MULT_MODE_LO;
      ir     <= '0;
      npc    <= '0;
      dest   <= '0;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      mode   <= prev_mode;
      ir     <= prev_ir;
      npc    <= prev_npc;
      dest   <= prev_dest;
      mplier <= prev_mplier >> CW;
      mcand  <= prev_mcand << CW;
      acc    <= next_acc;
    end else if (advance) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_pipe_stall.sv
// Pipelined unsigned multiplier with valid/ready backpressure, bubble collapsing and flush.
module mult_pipe_stall
  import mult_pipe_stall_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
  parameter int IR_W       = IR_W_DEFAULT,
  parameter int REG_W      = REG_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              mode_in,
  input  logic [XLEN-1:0]   mplier_in,
  input  logic [XLEN-1:0]   mcand_in,
  input  logic [IR_W-1:0]   IR_in,
  input  logic [NPC_W-1:0]  NPC_in,
  input  logic [REG_W-1:0]  dest_reg_in,
  input  logic              flush,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [XLEN-1:0]   product_out,
  output logic [IR_W-1:0]   IR_out,
  output logic [NPC_W-1:0]  NPC_out,
  output logic [REG_W-1:0]  dest_reg_out
);

  localparam int CW   = XLEN / NUM_STAGES;
  localparam int LAST = NUM_STAGES - 1;

  if (!stages_divide(XLEN, NUM_STAGES)) begin : g_bad_cfg
    $error("mult_pipe_stall: NUM_STAGES must divide XLEN");
  end

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] mode_q;
  logic [NUM_STAGES-1:0] advance;
  logic [NUM_STAGES-1:0] load;
  logic [IR_W-1:0]       ir_q     [NUM_STAGES];
  logic [NPC_W-1:0]      npc_q    [NUM_STAGES];
  logic [REG_W-1:0]      dest_q   [NUM_STAGES];
  logic [XLEN-1:0]       mplier_q [NUM_STAGES];
  logic [2*XLEN-1:0]     mcand_q  [NUM_STAGES];
  logic [2*XLEN-1:0]     acc_q    [NUM_STAGES];

  // Walk from the output backwards: a stage may move if the slot below is empty or emptying.
  always_comb begin
    logic take;
    advance = '0;
    load    = '0;
    take    = ready_in;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      advance[k] = valid_q[k] & take;
      take       = ~valid_q[k] | advance[k];
    end
    ready_out = take;
    load[0]   = valid_in & take & ~flush;
    for (int k = 1; k < NUM_STAGES; k++) begin
      load[k] = advance[k-1];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic              src_mode;
    logic [IR_W-1:0]   src_ir;
    logic [NPC_W-1:0]  src_npc;
    logic [REG_W-1:0]  src_dest;
    logic [XLEN-1:0]   src_mplier;
    logic [2*XLEN-1:0] src_mcand;
    logic [2*XLEN-1:0] src_acc;

    if (k == 0) begin : g_first
      assign src_mode   = mode_in;
      assign src_ir     = IR_in;
      assign src_npc    = NPC_in;
      assign src_dest   = dest_reg_in;
      assign src_mplier = mplier_in;
      assign src_mcand  = {{XLEN{1'b0}}, mcand_in};
      assign src_acc    = '0;
    end else begin : g_next
      assign src_mode   = mode_q[k-1];
      assign src_ir     = ir_q[k-1];
      assign src_npc    = npc_q[k-1];
      assign src_dest   = dest_q[k-1];
      assign src_mplier = mplier_q[k-1];
      assign src_mcand  = mcand_q[k-1];
      assign src_acc    = acc_q[k-1];
    end

    mult_pipe_stage #(
      .XLEN  (XLEN),
      .CW    (CW),
      .IR_W  (IR_W),
      .REG_W (REG_W)
    ) u_stage (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .load        (load[k]),
      .advance     (advance[k]),
      .prev_mode   (src_mode),
      .prev_ir     (src_ir),
      .prev_npc    (src_npc),
      .prev_dest   (src_dest),
      .prev_mplier (src_mplier),
      .prev_mcand  (src_mcand),
      .prev_acc    (src_acc),
      .valid       (valid_q[k]),
      .mode        (mode_q[k]),
      .ir          (ir_q[k]),
      .npc         (npc_q[k]),
      .dest        (dest_q[k]),
      .mplier      (mplier_q[k]),
      .mcand       (mcand_q[k]),
      .acc         (acc_q[k])
    );
  end

  assign valid_out    = valid_q[LAST];
  assign product_out  = (mode_q[LAST] == MULT_MODE_HI) ? acc_q[LAST][2*XLEN-1:XLEN]
                                                       : acc_q[LAST][XLEN-1:0];
  assign IR_out       = ir_q[LAST];
  assign NPC_out      = npc_q[LAST];
  assign dest_reg_out = dest_q[LAST];

endmodule
